l3_cache_assoc: RTL
===================

// Module: l3_cache_assoc
// PURPOSE
//  Parametrised set-associative, write-back, write-allocate L3 cache between the L2 miss path and main memory.
//  Generalises the direct-mapped L3 with configurable sets/ways/line length and per-word burst line fill and eviction.
//  Adds round-robin victim selection and a one-cycle req/resp handshake.
//  One outstanding request at a time.
// PARAMETERS
//  SETS            64   number of sets, power of 2, >=2
//  WAYS            4    ways per set, power of 2, >=1
//  WORDS_PER_LINE  4    32-bit words per line, power of 2, >=2
//  ADDR_WIDTH      32   byte address width
// PORTS
//  clk             in   1          single clock, rising edge
//  reset_n         in   1          asynchronous, active-low reset
//  req_valid       in   1          request present; sampled only in IDLE
//  req_write       in   1          1=write, 0=read
//  address         in   ADDR_WIDTH byte address; bits[1:0] ignored
//  writeData       in   32         write word
//  readData        out  32         read word, valid when resp_valid=1
//  resp_valid      out  1          one-cycle completion pulse (reads and writes)
//  hit             out  1          qualifies resp_valid: 1=hit, 0=serviced after miss
//  stall           out  1          miss in progress; requester holds req_* stable
//  mem_read        out  1          memory read beat request
//  mem_write       out  1          memory write beat request
//  mem_address     out  ADDR_WIDTH byte address of current beat
//  mem_write_data  out  32         write beat data
//  mem_read_data   in   32         read beat data, valid when mem_ready=1
//  mem_ready       in   1          beat accepted/completed this cycle
// BEHAVIOUR
//  Address split: OFF=log2(WORDS_PER_LINE)+2, IDX=log2(SETS), tag=address[ADDR_WIDTH-1:OFF+IDX].
//  Reset (async, reset_n=0): all valid/dirty bits and victim pointers cleared; FSM->IDLE.
//    readData=0, resp_valid=0, hit=0, stall=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
//    Reset mid-burst aborts immediately; the partially filled line is left invalid.
//  FSM: IDLE -> (miss) [EVICT] -> FILL -> RESPOND -> IDLE.
//  IDLE, req_valid=1: all ways of set compared in parallel.
//    Hit: next edge gives resp_valid=1, hit=1, readData=word (read) or word<=writeData with dirty=1 (write).
//      Victim pointer unchanged. Hit latency 1 cycle.
//    Miss: victim = lowest-numbered invalid way, else way at set's round-robin pointer. Next edge: stall=1.
//      Go to EVICT if victim valid&dirty, else FILL. Pointer advances (mod WAYS) only when a valid line is replaced.
//  EVICT: mem_write=1, beats 0..WORDS_PER_LINE-1 in order.
//    mem_address={victim_tag,idx,beat,2'b00}; data = victim word[beat].
//    Beat advances on each cycle with mem_ready=1. After the last beat: mem_write=0, dirty cleared, go to FILL.
//  FILL: mem_read=1, mem_address={tag,idx,beat,2'b00}, beats in order starting at 0.
//    mem_read_data captured into word[beat] when mem_ready=1.
//    After last beat: mem_read=0, tag written, valid=1, go to RESPOND.
//  RESPOND: completes as a hit, with hit=0.
//    Read returns word; write merges writeData, dirty=1. resp_valid=1, stall=0 on the edge leaving RESPOND.
//  mem_read and mem_write are never high together. mem_ready is ignored outside EVICT/FILL.
//  req_valid during stall is ignored; no new request is accepted in the RESPOND cycle.
//  mem_ready may stall indefinitely; the FSM waits with address/data held stable.
//  resp_valid is a single-cycle pulse; readData holds until the next read response.
// TESTING
//  Cold read 0x0000_1004, memory words 0xA0..0xA3 -> 4 FILL beats at 0x1000..0x100C;
//    resp_valid,hit=0, readData=0xA1.
//  Repeat read 0x0000_1004 -> resp_valid 1 cycle after req_valid, hit=1, readData=0xA1, no mem_* activity.
//  Write 0xDEAD_BEEF to 0x1008, then fill WAYS+1 distinct tags into the same set
//    -> exactly one EVICT burst from base 0x1000, beat 2 data 0xDEADBEEF.
//  Clean line replaced (after cycling 5 tags through 4 ways) -> no mem_write asserted, FILL only.
//    Victim is round-robin way 0.
//  mem_ready held low 10 cycles mid-FILL -> mem_address/mem_read stable, stall=1 throughout.
//  reset_n low during EVICT beat 1 -> mem_write=0 immediately; post-reset read of the same address misses.

Source files
------------

// File: rtl/l3_cache_assoc.sv
// Set-associative write-back, write-allocate L3 cache with round-robin replacement
// and word-serial line eviction/fill toward main memory; one request in flight.
module l3_cache_assoc #(
    parameter int SETS           = 64,
    parameter int WAYS           = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData,
    output logic                  resp_valid,
    output logic                  hit,
    output logic                  stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data,
    input  logic                  mem_ready
);
    localparam int BW  = $clog2(WORDS_PER_LINE);
    localparam int OFF = BW + 2;
    localparam int IW  = $clog2(SETS);
    localparam int TW  = ADDR_WIDTH - OFF - IW;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NW  = 1 << WW;

    typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL, S_RESPOND} state_t;

    logic [31:0]        data_mem [SETS*NW*WORDS_PER_LINE];
    logic [TW-1:0]      tag_mem  [SETS*NW];
    logic [SETS*NW-1:0] valid_q, dirty_q;
    logic [WW-1:0]      rr_q     [SETS];

    state_t             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d, beat_nxt;
    logic [TW-1:0]      lat_tag_q, lat_tag_d;
    logic [IW-1:0]      lat_idx_q, lat_idx_d;
    logic [BW-1:0]      lat_word_q, lat_word_d;
    logic               lat_write_q, lat_write_d;
    logic [31:0]        lat_wdata_q, lat_wdata_d;
    logic [WW-1:0]      victim_q, victim_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               resp_valid_q, resp_valid_d;
    logic               hit_q, hit_d;
    logic               stall_q, stall_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic [TW-1:0]      req_tag, victim_tag;
    logic [IW-1:0]      req_idx;
    logic [BW-1:0]      req_word;
    logic [WAYS-1:0]    hit_vec, inv_vec;
    logic               lookup_hit, inv_found, miss_dirty;
    logic [WW-1:0]      hit_way, inv_way, miss_way;
    logic               data_we, tag_we, valid_set, dirty_set, dirty_clr, rr_adv;
    logic [IW+WW+BW-1:0] data_waddr;
    logic [31:0]        data_wdata;
    logic [IW+WW-1:0]   vd_sel;
    logic               unused_addr_bits;

    assign req_tag          = address[ADDR_WIDTH-1:OFF+IW];
    assign req_idx          = address[OFF+IW-1:OFF];
    assign req_word         = address[OFF-1:2];
    assign unused_addr_bits = &{1'b0, address[1:0]};

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign hit_vec[gi] = valid_q[{req_idx, WW'(gi)}] && (tag_mem[{req_idx, WW'(gi)}] == req_tag);
        assign inv_vec[gi] = !valid_q[{req_idx, WW'(gi)}];
    end

    // Descending scan so the lowest-numbered matching way wins.
    always_comb begin
        lookup_hit = |hit_vec;
        inv_found  = |inv_vec;
        hit_way    = '0;
        inv_way    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WW'(w);
            if (inv_vec[w]) inv_way = WW'(w);
        end
    end

    assign miss_way   = inv_found ? inv_way : rr_q[req_idx];
    assign miss_dirty = !inv_found && dirty_q[{req_idx, rr_q[req_idx]}];
    assign victim_tag = tag_mem[{lat_idx_q, victim_q}];
    assign beat_nxt   = beat_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        lat_tag_d     = lat_tag_q;
        lat_idx_d     = lat_idx_q;
        lat_word_d    = lat_word_q;
        lat_write_d   = lat_write_q;
        lat_wdata_d   = lat_wdata_q;
        victim_d      = victim_q;
        read_data_d   = read_data_q;
        resp_valid_d  = 1'b0;
        hit_d         = hit_q;
        stall_d       = stall_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        data_we       = 1'b0;
        data_waddr    = {lat_idx_q, victim_q, beat_q};
        data_wdata    = mem_read_data;
        tag_we        = 1'b0;
        vd_sel        = {lat_idx_q, victim_q};
        valid_set     = 1'b0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        rr_adv        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && lookup_hit) begin
                    resp_valid_d = 1'b1;
                    hit_d        = 1'b1;
                    if (req_write) begin
                        data_we    = 1'b1;
                        data_waddr = {req_idx, hit_way, req_word};
                        data_wdata = writeData;
                        vd_sel     = {req_idx, hit_way};
                        dirty_set  = 1'b1;
                    end else begin
                        read_data_d = data_mem[{req_idx, hit_way, req_word}];
                    end
                end else if (req_valid) begin
                    stall_d     = 1'b1;
                    lat_tag_d   = req_tag;
                    lat_idx_d   = req_idx;
                    lat_word_d  = req_word;
                    lat_write_d = req_write;
                    lat_wdata_d = writeData;
                    victim_d    = miss_way;
                    beat_d      = '0;
                    rr_adv      = !inv_found;
                    if (miss_dirty) begin
                        state_d       = S_EVICT;
                        mem_write_d   = 1'b1;
                        mem_address_d = {tag_mem[{req_idx, miss_way}], req_idx, {BW{1'b0}}, 2'b00};
                        mem_wdata_d   = data_mem[{req_idx, miss_way, {BW{1'b0}}}];
                    end else begin
                        state_d       = S_FILL;
                        mem_read_d    = 1'b1;
                        mem_address_d = {req_tag, req_idx, {BW{1'b0}}, 2'b00};
                    end
                end
            end
            S_EVICT: begin
                if (mem_ready) begin
                    if (&beat_q) begin
                        mem_write_d   = 1'b0;
                        dirty_clr     = 1'b1;
                        state_d       = S_FILL;
                        mem_read_d    = 1'b1;
                        beat_d        = '0;
                        mem_address_d = {lat_tag_q, lat_idx_q, {BW{1'b0}}, 2'b00};
                    end else begin
                        beat_d        = beat_nxt;
                        mem_address_d = {victim_tag, lat_idx_q, beat_nxt, 2'b00};
                        mem_wdata_d   = data_mem[{lat_idx_q, victim_q, beat_nxt}];
                    end
                end
            end
            S_FILL: begin
                if (mem_ready) begin
                    data_we = 1'b1;
                    if (&beat_q) begin
                        mem_read_d = 1'b0;
                        tag_we     = 1'b1;
                        valid_set  = 1'b1;
                        state_d    = S_RESPOND;
                    end else begin
                        beat_d        = beat_nxt;
                        mem_address_d = {lat_tag_q, lat_idx_q, beat_nxt, 2'b00};
                    end
                end
            end
            S_RESPOND: begin
                resp_valid_d = 1'b1;
                hit_d        = 1'b0;
                stall_d      = 1'b0;
                state_d      = S_IDLE;
                if (lat_write_q) begin
                    data_we    = 1'b1;
                    data_waddr = {lat_idx_q, victim_q, lat_word_q};
                    data_wdata = lat_wdata_q;
                    dirty_set  = 1'b1;
                end else begin
                    read_data_d = data_mem[{lat_idx_q, victim_q, lat_word_q}];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            lat_tag_q     <= '0;
            lat_idx_q     <= '0;
            lat_word_q    <= '0;
            lat_write_q   <= 1'b0;
            lat_wdata_q   <= '0;
            victim_q      <= '0;
            read_data_q   <= '0;
            resp_valid_q  <= 1'b0;
            hit_q         <= 1'b0;
            stall_q       <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            valid_q       <= '0;
            dirty_q       <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            lat_tag_q     <= lat_tag_d;
            lat_idx_q     <= lat_idx_d;
            lat_word_q    <= lat_word_d;
            lat_write_q   <= lat_write_d;
            lat_wdata_q   <= lat_wdata_d;
            victim_q      <= victim_d;
            read_data_q   <= read_data_d;
            resp_valid_q  <= resp_valid_d;
            hit_q         <= hit_d;
            stall_q       <= stall_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            if (valid_set) valid_q[vd_sel] <= 1'b1;
            if (dirty_set) dirty_q[vd_sel] <= 1'b1;
            if (dirty_clr) dirty_q[vd_sel] <= 1'b0;
            // A single-way cache keeps its pointer pinned at way 0.
            if (rr_adv) rr_q[req_idx] <= (WAYS > 1) ? rr_q[req_idx] + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_waddr] <= data_wdata;
        if (tag_we)  tag_mem[{lat_idx_q, victim_q}] <= lat_tag_q;
    end

    assign readData       = read_data_q;
    assign resp_valid     = resp_valid_q;
    assign hit            = hit_q;
    assign stall          = stall_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_wdata_q;
endmodule
